// File: rtl/alu_rr_sched_pkg.sv
// alu_sched_pkg
// Shared definitions for the round-robin ALU scheduler:
//   - op-code constants understood by the shared 4-bit ALU
//     (the scheduler itself passes op codes through untouched)
//   - FSM state encoding for alu_rr_sched
package alu_sched_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_sched_rr_pick.sv
// rr_pick
// Combinational round-robin winner finder. The search starts one past
// the previously served requester and wraps around, so the requester
// that was served last always has the lowest priority.
// Ports:
//   req       - per-requester valid vector
//   last      - index of the requester served last
//   grant     - one-hot winner (all zero when nobody is requesting)
//   grant_idx - binary index of the winner
//   any_valid - at least one requester is valid
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  // Walk the candidates in priority order; the first valid one wins
  // and any_valid then masks every later candidate.
  always_comb begin
    logic [IDW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!any_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any_valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched
// Round-robin scheduler that shares one combinational ALU between NREQ
// requesters. One request is accepted at a time, the ALU is driven
// from registered operands for one cycle, and the captured result is
// returned with the requester index over a valid/ready channel.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   req_valid/req_ready - per-requester handshake (ready is one-hot)
//   req_a/req_b/req_ctrl- packed per-requester payload, slot i at [i*w +: w]
//   alu_a/alu_b/alu_ctrl- operands to the shared ALU (hold value outside EXEC)
//   alu_res/car/of      - ALU outputs, captured at the end of EXEC
//   rsp_*               - response channel (id, result, carry, overflow)
// Optional feature (macro ALU_RR_SCHED_STATS_EN):
//   stat_ops - per-requester saturating 8-bit handshake counters
//   stat_of  - saturating count of delivered responses with overflow set
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 4,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_ctrl,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [W-1:0]    alu_res,
  input  logic            alu_car,
  input  logic            alu_of,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_res,
  output logic            rsp_car,
`ifdef ALU_RR_SCHED_STATS_EN
  output logic            rsp_of,
  output logic [NREQ*8-1:0] stat_ops,
  output logic [7:0]      stat_of
`else
  output logic            rsp_of
`endif
);

  state_t         state, state_nxt;
  logic [IDW-1:0] last;
  logic [IDW-1:0] grant_id;
  logic [W-1:0]   op_a, op_b;
  logic [2:0]     op_ctrl;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           req_hs;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req       (req_valid),
    .last      (last),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  // The op registers are only written on a handshake, so they already
  // hold steady through EXEC and keep their last value afterwards.
  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_ctrl = op_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Grants are only offered in IDLE; rst_n gates them so nothing looks
  // accepted while the block is held in reset.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    req_hs    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rst_n) req_ready = pick_grant;
        if (pick_any) begin
          req_hs    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, pointer update and response capture. The pointer
  // resets to the last index so requester 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= IDW'(NREQ - 1);
      grant_id  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_ctrl   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= '0;
      rsp_car   <= 1'b0;
      rsp_of    <= 1'b0;
    end else begin
      if (req_hs) begin
        op_a     <= req_a[pick_idx*W +: W];
        op_b     <= req_b[pick_idx*W +: W];
        op_ctrl  <= req_ctrl[pick_idx*3 +: 3];
        grant_id <= pick_idx;
        last     <= pick_idx;
      end
      if (state == S_EXEC) begin
        rsp_res   <= alu_res;
        rsp_car   <= alu_car;
        rsp_of    <= alu_of;
        rsp_id    <= grant_id;
        rsp_valid <= 1'b1;
      end
      if (state == S_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_RR_SCHED_STATS_EN
  // Saturating usage counters: ops per requester at request handshake,
  // overflowing results at response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_of  <= '0;
    end else begin
      if (req_hs && stat_ops[pick_idx*8 +: 8] != 8'hFF)
        stat_ops[pick_idx*8 +: 8] <= stat_ops[pick_idx*8 +: 8] + 8'd1;
      if (state == S_RESP && rsp_ready && rsp_of && stat_of != 8'hFF)
        stat_of <= stat_of + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched
// Directed bench for alu_rr_sched with NREQ=2, W=4. A small behavioural
// 4-bit ALU sits on the alu_* ports; expected results are hand-computed
// constants. Stats counters are exercised when ALU_RR_SCHED_STATS_EN
// is defined.
module tb_alu_rr_sched;
  import alu_sched_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a, req_b;
  logic [5:0] req_ctrl;
  logic [3:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_ctrl;
  logic       alu_car, alu_of;
  logic       rsp_valid, rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_res;
  logic       rsp_car, rsp_of;
`ifdef ALU_RR_SCHED_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_of;
`endif

  int checks   = 0;
  int failures = 0;

  alu_rr_sched #(.NREQ(2), .W(4), .IDW(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_res   (alu_res),
    .alu_car   (alu_car),
    .alu_of    (alu_of),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_car   (rsp_car),
`ifdef ALU_RR_SCHED_STATS_EN
    .rsp_of    (rsp_of),
    .stat_ops  (stat_ops),
    .stat_of   (stat_of)
`else
    .rsp_of    (rsp_of)
`endif
  );

  // 100 MHz-style clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU: carry is carry-out for add
  // and borrow for sub, overflow is two's-complement overflow.
  always_comb begin
    logic [4:0] wide;
    wide    = '0;
    alu_res = '0;
    alu_car = 1'b0;
    alu_of  = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        wide    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res = wide[3:0];
        alu_car = wide[4];
        alu_of  = (alu_a[3] == alu_b[3]) && (wide[3] != alu_a[3]);
      end
      OP_SUB: begin
        wide    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res = wide[3:0];
        alu_car = wide[4];
        alu_of  = (alu_a[3] != alu_b[3]) && (wide[3] != alu_a[3]);
      end
      OP_NOT: alu_res = ~alu_a;
      OP_AND: alu_res = alu_a & alu_b;
      OP_OR:  alu_res = alu_a | alu_b;
      OP_XOR: alu_res = alu_a ^ alu_b;
      OP_LT:  alu_res = {3'b000, alu_a < alu_b};
      OP_EQ:  alu_res = {3'b000, alu_a == alu_b};
      default: alu_res = '0;
    endcase
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [3:0] a,
                               input logic [3:0] b, input logic [2:0] ctrl);
    req_a[idx*4 +: 4]    = a;
    req_b[idx*4 +: 4]    = b;
    req_ctrl[idx*3 +: 3] = ctrl;
  endtask

  // One complete single-requester operation with rsp_ready held high.
  task automatic doOp(input int idx, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] ctrl, input logic [3:0] eres,
                      input logic ecar, input logic eof, input string tag);
    applyStimulus(idx, a, b, ctrl);
    rsp_ready = 1'b1;
    req_valid = 2'(1 << idx);
    #1;
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    tick();
    req_valid = 2'b00;
    checkOutput({tag, "_alu_a"}, 32'(alu_a), 32'(a));
    checkOutput({tag, "_alu_b"}, 32'(alu_b), 32'(b));
    checkOutput({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'(ctrl));
    checkOutput({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_id"}, 32'(rsp_id), 32'(idx));
    checkOutput({tag, "_res"}, 32'(rsp_res), 32'(eres));
    checkOutput({tag, "_car"}, 32'(rsp_car), 32'(ecar));
    checkOutput({tag, "_of"}, 32'(rsp_of), 32'(eof));
    tick();
    checkOutput({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = 8'h00;
    req_b     = 8'h00;
    req_ctrl  = 6'o00;
    rsp_ready = 1'b1;
    #2;
    // Held in reset with both requesters asking: nothing may be granted.
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_res", 32'(rsp_res), 32'd0);
    checkOutput("rst_alu", 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
    tick();
    tick();
    req_valid = 2'b00;
    rst_n     = 1'b1;
    tick();

    // Basic add with signed overflow, then carry-out from requester 1.
    applyStimulus(1, 4'h3, 4'h3, OP_XOR);
    doOp(0, 4'h7, 4'h1, OP_ADD, 4'h8, 1'b0, 1'b1, "add");
    applyStimulus(0, 4'h5, 4'h5, OP_OR);
    doOp(1, 4'hF, 4'h1, OP_ADD, 4'h0, 1'b1, 1'b0, "carry");

    // Contention: both valid continuously, grants must alternate.
    applyStimulus(0, 4'hC, 4'hA, OP_AND);
    applyStimulus(1, 4'h5, 4'h3, OP_SUB);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #0;
      checkOutput("cont_grant", 32'(req_ready), (n % 2 == 1) ? 32'd2 : 32'd1);
      tick();
      tick();
      checkOutput("cont_valid", 32'(rsp_valid), 32'd1);
      checkOutput("cont_id", 32'(rsp_id), 32'(n % 2));
      checkOutput("cont_res", 32'(rsp_res), (n % 2 == 1) ? 32'd2 : 32'd8);
      tick();
    end
    req_valid = 2'b00;

    // Backpressure: response must hold and requests stay blocked.
    applyStimulus(0, 4'h2, 4'h3, OP_ADD);
    applyStimulus(1, 4'h1, 4'h1, OP_ADD);
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #1;
    checkOutput("bp_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b10;
    tick();
    checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_hold_res", 32'({rsp_id, rsp_car, rsp_of, rsp_res}), 32'h05);
      checkOutput("bp_blocked", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_release", 32'(rsp_valid), 32'd0);
    checkOutput("bp_next_grant", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    tick();
    checkOutput("bp_r1_id", 32'(rsp_id), 32'd1);
    checkOutput("bp_r1_res", 32'(rsp_res), 32'd2);
    tick();
    checkOutput("bp_r1_done", 32'(rsp_valid), 32'd0);

    // Reset while an op sits in EXEC: op dropped, pointer back to req0.
    applyStimulus(0, 4'h9, 4'h9, OP_ADD);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    checkOutput("mid_exec_a", 32'(alu_a), 32'h9);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
    checkOutput("mid_rst_alu", 32'(alu_a), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = 2'b11;
    #1;
    checkOutput("mid_first_grant", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    #1;

`ifdef ALU_RR_SCHED_STATS_EN
    rst_n = 1'b0;
    #1;
    checkOutput("st_rst_ops", 32'(stat_ops), 32'd0);
    checkOutput("st_rst_of", 32'(stat_of), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    doOp(0, 4'h7, 4'h1, OP_ADD, 4'h8, 1'b0, 1'b1, "st_a");
    doOp(0, 4'h1, 4'h2, OP_ADD, 4'h3, 1'b0, 1'b0, "st_b");
    doOp(0, 4'hC, 4'hA, OP_AND, 4'h8, 1'b0, 1'b0, "st_c");
    doOp(1, 4'h2, 4'h2, OP_EQ, 4'h1, 1'b0, 1'b0, "st_d");
    checkOutput("st_ops", 32'(stat_ops), 32'h0103);
    checkOutput("st_of", 32'(stat_of), 32'd1);
    for (int n = 0; n < 300; n++)
      doOp(0, 4'h1, 4'h1, OP_ADD, 4'h2, 1'b0, 1'b0, "st_sat");
    checkOutput("st_sat0", 32'(stat_ops[7:0]), 32'd255);
    checkOutput("st_sat1", 32'(stat_ops[15:8]), 32'd1);
    checkOutput("st_sat_of", 32'(stat_of), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
